cassette_stream: RTL
====================

Name: cassette_stream

Overview:
- Parametrised successor to the single-speed cassette player.
- Streams tape image bytes from SDRAM through a prefetch FIFO and serialises each byte LSB-first as FSK square-wave cycles on the cassette input line.
- Runtime-programmable bit periods, tape length and mark/space polarity; play/pause, rewind and end-of-tape detection.
- Sits between the sdram read port and the machine's cin input.

Parameters:
- ADDR_W, 25: tape byte address width.
- DIV_W, 16: width of half-period counters.
- FIFO_DEPTH, 4: prefetch byte FIFO entries; power of 2, at least 2.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- play_pause  in  1  one-cycle pulse; toggles play/pause.
- rewind  in  1  one-cycle pulse; return to tape start, stop.
- tape_len  in  ADDR_W  number of valid bytes in image; sampled on play start.
- half0  in  DIV_W  clk_sys cycles per half-cycle of a 0 bit; 0 treated as 1.
- half1  in  DIV_W  clk_sys cycles per half-cycle of a 1 bit; 0 treated as 1.
- invert  in  1  invert data output.
- mem_addr  out  ADDR_W  byte address of outstanding read.
- mem_rd  out  1  one-cycle read request.
- mem_data  in  8  read data.
- mem_valid  in  1  one-cycle strobe; mem_data valid.
- data  out  1  cassette signal.
- playing  out  1  state is PLAY.
- at_end  out  1  state is END.
- underrun  out  1  sticky; FIFO empty while a bit was due.
- position  out  ADDR_W  index of byte currently being serialised.

Behaviour:
- Reset values: all outputs 0 (data = invert is not applied in reset: data=0); FIFO empty; fetch address 0; state STOP.
- States and transitions:
  - STOP: play_pause goes to PLAY, latching tape_len into len_q. If len_q=0, goes to END instead.
  - PLAY: play_pause goes to PAUSE.
  - PAUSE: play_pause goes to PLAY.
  - END: entered after the last half-cycle of byte len_q-1 completes. play_pause is ignored in END.
  - rewind from any state goes to STOP and:
    - flushes the FIFO;
    - zeroes the fetch address, position and bit counters;
    - clears underrun.
  - If rewind and play_pause occur in the same cycle, rewind wins.
- Fetch engine (active in STOP, PLAY and PAUSE; suspended in END):
  - At most one outstanding read.
  - Issues mem_rd for 1 cycle with mem_addr = fetch address when no read is outstanding, FIFO occupancy plus outstanding is below FIFO_DEPTH, and fetch address < len_q.
  - In STOP, the fetch limit is tape_len live.
  - mem_addr holds stable until mem_valid.
  - On mem_valid: push mem_data and increment the fetch address.
  - mem_valid with no outstanding read is ignored.
  - Rewind with a read outstanding sets a discard flag; the next mem_valid is dropped.
- Serialiser (PLAY only):
  - Pops a byte when idle and the FIFO is non-empty; pop occurs the cycle after the byte enters the FIFO.
  - Emits bits 0..7. Each bit is a high phase of H cycles, then a low phase of H cycles, where H = half1 if the bit is 1, else half0.
  - H is sampled at bit start.
  - data = phase XOR invert.
  - The next byte pops in the same cycle the last low phase ends; no gap if the FIFO is non-empty.
  - position increments when a byte completes.
- Underrun: the serialiser needs a byte, the FIFO is empty, and position < len_q.
  - underrun=1, data holds low (XOR invert), serialisation stalls and resumes on the next push.
- PAUSE:
  - Counters, phase and data freeze.
  - Resuming continues the same half-cycle with the remaining count.
- END: data = invert, position = len_q.
- Arithmetic:
  - Fetch address and position are ADDR_W bits, no wrap; bounded by len_q.
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits for full/empty distinction.

Test Plan:
- tape_len=1, mem byte 0x01, half0=4, half1=2, play_pause:
  - data = 1,1,0,0 (bit0=1), then seven cycles of 1111 0000;
  - then at_end=1; total 4+56=60 cycles after first pop;
  - exactly one mem_rd at addr 0.
- tape_len=0, play_pause -> at_end=1 next cycle; no mem_rd ever; data=0.
- tape_len=8, FIFO_DEPTH=4, mem_valid returned 3 cycles after each mem_rd, stopped:
  - exactly 4 reads issued (addr 0..3), then no mem_rd until a byte pops.
- Playing byte 0xFF, half1=3: pause mid high phase after 1 cycle -> data frozen 1 for 50 cycles; resume -> exactly 2 more high cycles then 3 low.
- Withhold mem_valid during play after FIFO drains -> underrun=1, data=0; deliver 0xAA -> serialisation resumes with bit0=0 using half0; rewind clears underrun.
- Rewind while a read of addr 5 is outstanding, then the mem_valid arrives:
  - the byte is discarded and the FIFO stays empty;
  - next mem_rd addr = 0; position=0; state STOP;
  - simultaneous rewind+play_pause -> STOP.

Source files
------------

// File: rtl/cassette_stream.sv
// Tape image streamer: prefetches bytes from SDRAM into a small FIFO and
// serialises them LSB-first as FSK square-wave cycles on the cassette line.
module cassette_stream #(
    parameter int ADDR_W     = 25,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              play_pause,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] tape_len,
    input  logic [DIV_W-1:0]  half0,
    input  logic [DIV_W-1:0]  half1,
    input  logic              invert,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic              data,
    output logic              playing,
    output logic              at_end,
    output logic              underrun,
    output logic [ADDR_W-1:0] position
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE, ST_END} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic              rd_q, rd_d;
    logic              outst_q, outst_d;
    logic              discard_q, discard_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              active_q, active_d;
    logic              phase_q, phase_d;
    logic              underrun_q, underrun_d;
    logic              data_q, data_d;
    logic [7:0]        sr_q, sr_d;
    logic [2:0]        bit_q, bit_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  h_q, h_d;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fill;
    logic [OCC_W-1:0]  occ;
    logic              fifo_empty;
    logic [7:0]        fifo_head;
    logic [ADDR_W-1:0] fetch_lim;
    logic [ADDR_W-1:0] pos_inc;
    logic [DIV_W-1:0]  h_head, h_next;
    logic              push, pop, load;

    function automatic logic [DIV_W-1:0] half_of(input logic b);
        logic [DIV_W-1:0] h;
        h = b ? half1 : half0;
        return (h == '0) ? DIV_W'(1) : h;
    endfunction

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign occ        = {1'b0, fill} + {{PTR_W{1'b0}}, outst_q};
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = fifo_mem[rd_ptr_q[IDX_W-1:0]];
    assign fetch_lim  = (state_q == ST_STOP) ? tape_len : len_q;
    assign pos_inc    = pos_q + ADDR_W'(1);
    assign h_head     = half_of(fifo_head[0]);
    assign h_next     = half_of(sr_q[1]);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        faddr_d    = faddr_q;
        pos_d      = pos_q;
        rd_d       = 1'b0;
        outst_d    = outst_q;
        discard_d  = discard_q;
        active_d   = active_q;
        phase_d    = phase_q;
        underrun_d = underrun_q;
        sr_d       = sr_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        h_d        = h_q;
        push       = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_STOP:  if (play_pause) begin
                          len_d   = tape_len;
                          state_d = (tape_len == '0) ? ST_END : ST_PLAY;
                      end
            ST_PLAY:  if (play_pause) state_d = ST_PAUSE;
            ST_PAUSE: if (play_pause) state_d = ST_PLAY;
            default:  ;
        endcase

        if (mem_valid && outst_q) begin
            outst_d = 1'b0;
            if (discard_q) begin
                discard_d = 1'b0;
            end else if (!rewind) begin
                push    = 1'b1;
                faddr_d = faddr_q + ADDR_W'(1);
            end
        end
        if (!rewind && state_q != ST_END && !outst_q && occ < DEPTH_C &&
            faddr_q < fetch_lim) begin
            rd_d    = 1'b1;
            outst_d = 1'b1;
        end

        if (state_q == ST_PLAY) begin
            if (!active_q) begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end else if (pos_q < len_q) begin
                    underrun_d = 1'b1;
                    phase_d    = 1'b0;
                end
            end else if (cnt_q > DIV_W'(1)) begin
                cnt_d = cnt_q - DIV_W'(1);
            end else if (phase_q) begin
                phase_d = 1'b0;
                cnt_d   = h_q;
            end else if (bit_q != 3'd7) begin
                bit_d   = bit_q + 3'd1;
                sr_d    = sr_q >> 1;
                h_d     = h_next;
                cnt_d   = h_next;
                phase_d = 1'b1;
            end else begin
                // Last low phase of a byte: either finish the tape or chain
                // straight into the next byte without an idle cycle.
                pos_d = pos_inc;
                if (pos_inc == len_q) begin
                    state_d  = ST_END;
                    active_d = 1'b0;
                    phase_d  = 1'b0;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    active_d = 1'b0;
                    phase_d  = 1'b0;
                end
            end
        end

        if (load) begin
            sr_d     = fifo_head;
            bit_d    = '0;
            phase_d  = 1'b1;
            h_d      = h_head;
            cnt_d    = h_head;
            active_d = 1'b1;
        end
        pop      = load;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        if (rewind) begin
            state_d    = ST_STOP;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            faddr_d    = '0;
            pos_d      = '0;
            bit_d      = '0;
            cnt_d      = '0;
            active_d   = 1'b0;
            phase_d    = 1'b0;
            underrun_d = 1'b0;
            outst_d    = outst_q & ~mem_valid;
            discard_d  = outst_q & ~mem_valid;
        end

        data_d = (state_d == ST_END) ? invert : (phase_d ^ invert);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_STOP;
            len_q      <= '0;
            faddr_q    <= '0;
            pos_q      <= '0;
            rd_q       <= 1'b0;
            outst_q    <= 1'b0;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            active_q   <= 1'b0;
            phase_q    <= 1'b0;
            underrun_q <= 1'b0;
            data_q     <= 1'b0;
            sr_q       <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            h_q        <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            faddr_q    <= faddr_d;
            pos_q      <= pos_d;
            rd_q       <= rd_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            active_q   <= active_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
            data_q     <= data_d;
            sr_q       <= sr_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            h_q        <= h_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_ptr_q[IDX_W-1:0]] <= mem_data;
    end

    assign mem_addr = faddr_q;
    assign mem_rd   = rd_q;
    assign data     = data_q;
    assign playing  = (state_q == ST_PLAY);
    assign at_end   = (state_q == ST_END);
    assign underrun = underrun_q;
    assign position = pos_q;

endmodule
